probe_tx: RTL and testbench
===========================

Name: probe_tx

Overview:
- Transmit side of the target-probe link in the timing-attack rig.
- Takes one candidate word from the brute-force sequencer over a valid/ready handshake.
- Shifts the word to the target as a UART-style serial frame.
- Then opens a fixed observation window by driving the enable that the response trigger consumes. The trigger flags target responses only while this window is open.

Parameters:
- DATA_W, 8, width of the candidate word (1..16).
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- WINDOW_CYCLES, 1024, cycles win_en stays high after the stop bit (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  candidate word, sampled only on the handshake.
- data_valid  in  1  sequencer offers data_in.
- data_ready  out  1  block can accept a word.
- abort  in  1  synchronous cancel of the current probe.
- tx  out  1  serial line to the target, idle high.
- win_en  out  1  observation window, to the trigger's enable input.
- busy  out  1  high from the cycle after accept until the return to IDLE.
- done  out  1  one-cycle pulse when a probe completes without abort.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - state=IDLE, tx=1, win_en=0, data_ready=1, busy=0, done=0.
  - Shift register and counters cleared.
- All outputs are registered.
- States: IDLE, START, DATA, STOP, WINDOW.
- IDLE:
  - data_ready=1, tx=1.
  - data_valid&data_ready at edge k: latch data_in, go to START. From cycle k+1: data_ready=0, busy=1.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - DATA_W bits, LSB first, each held CLKS_PER_BIT cycles.
  - data_in changes after the accept cycle have no effect.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- WINDOW:
  - win_en=1 for exactly WINDOW_CYCLES cycles, tx=1.
  - First win_en cycle immediately follows the last stop-bit cycle.
- Completion:
  - The cycle after the last win_en cycle: done=1 (one cycle), state=IDLE, data_ready=1, busy=0.
  - A word offered in that same cycle is accepted there, giving back-to-back frames with no extra gap.
- Frame length, accept to window start: (DATA_W+2)*CLKS_PER_BIT cycles.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter width is $clog2(DATA_W+1).
  - Window counter width is $clog2(WINDOW_CYCLES+1).
- abort:
  - Any non-IDLE state, next edge: IDLE, tx=1, win_en=0, busy=0, data_ready=1, no done.
  - In IDLE, abort has priority over data_valid: nothing is accepted that cycle.
- data_valid while busy is ignored; the word is not queued.

Optional Feature:
- Macro PROBE_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries the even parity (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no parity state and no parity logic.

Decomposition:
- Shared package probe_pkg holds:
  - The state enum typedef (probe_state_t).
  - The idle line level constant.
  - The default CLKS_PER_BIT and WINDOW_CYCLES values, also used by the trigger-side bench.
- One sub-module, bit_timer:
  - Parameterised CLKS_PER_BIT.
  - Inputs clear and run; output tick pulses on the last cycle of each bit period.
  - Instantiated once.

Test Plan:
All cases use DATA_W=8, CLKS_PER_BIT=4, WINDOW_CYCLES=16.
- Send 0xA5:
  - tx per 4-cycle slot is 0 | 1,0,1,0,0,1,0,1 | 1.
  - win_en high for 16 cycles starting 40 cycles after accept.
  - done pulses once, 56 cycles after accept.
- data_valid held high with 0x3C then 0xC3:
  - Second word is accepted in the done cycle of the first.
  - Second start bit begins on the next cycle, with no idle gap.
- abort asserted during DATA bit 3 of 0xFF:
  - Next cycle tx=1, busy=0, data_ready=1.
  - win_en never rises; done stays 0.
- rst_n pulled low mid-WINDOW (asynchronous):
  - win_en=0 and tx=1 before the next clock edge; state IDLE after release.
- data_in toggled and data_valid pulsed during frame 0x5A:
  - Transmitted bits still encode 0x5A.
  - Nothing extra is accepted.
- PROBE_TX_PARITY_EN defined:
  - 0xA5 adds a parity slot of 0; 0x01 adds a parity slot of 1.
  - win_en starts 44 cycles after accept.

Source files
------------

// File: rtl/probe_pkg.sv
// Shared definitions for the target-probe link: probe_tx FSM states, the
// serial idle level and the default timing used by both link ends.
// PROBE_TX_PARITY_EN adds the PARITY state to the enum.
package probe_pkg;

   `ifdef PROBE_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_WINDOW = 3'd5
   } probe_state_t;
   `else
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4,
      ST_WINDOW = 3'd5
   } probe_state_t;
   `endif

   // Serial line level between frames (UART mark)
   localparam logic LINE_IDLE = 1'b1;

   // Default link timing, shared with the trigger-side bench
   localparam int DEF_CLKS_PER_BIT  = 16;
   localparam int DEF_WINDOW_CYCLES = 1024;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer for probe_tx: counts 0..CLKS_PER_BIT-1 while run is high
// and flags the last cycle of each bit period on tick.
module bit_timer
   import probe_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = run && (cnt_q == CNT_LAST);

   // Next count: clear wins, otherwise advance and wrap on the last cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/probe_tx.sv
// probe_tx: accepts a candidate word over valid/ready, sends it as a
// UART-style frame (start, DATA_W bits LSB first, stop) and then holds
// win_en high for WINDOW_CYCLES so the response trigger can listen.
// Optional feature macro: PROBE_TX_PARITY_EN (even parity slot before stop).
// Outputs are registered; their next values are derived from the next state
// so every output changes on the same edge as the state it belongs to.
module probe_tx
   import probe_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              abort,
   output logic              tx,
   output logic              win_en,
   output logic              busy,
   output logic              done
);

   localparam int BIT_CNT_W = $clog2(DATA_W + 1);
   localparam int WIN_CNT_W = $clog2(WINDOW_CYCLES + 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_W - 1);
   localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WINDOW_CYCLES - 1);

   probe_state_t state_q, state_d;

   logic [DATA_W-1:0]    shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
   `ifdef PROBE_TX_PARITY_EN
   logic                 parity_q, parity_d;
   `endif

   logic tx_q, tx_d;
   logic win_en_q, win_en_d;
   logic ready_q, ready_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic accept;
   logic tick;
   logic timer_run;

   // abort in IDLE blocks the handshake for that cycle
   assign accept = (state_q == ST_IDLE) && data_valid && !abort;

   // The timer only runs while a bit of the frame is on the line
   assign timer_run = (state_q != ST_IDLE) && (state_q != ST_WINDOW);

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept || abort),
      .run   (timer_run),
      .tick  (tick)
   );

   // State, shift register and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         win_cnt_q <= '0;
         `ifdef PROBE_TX_PARITY_EN
         parity_q  <= 1'b0;
         `endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         win_cnt_q <= win_cnt_d;
         `ifdef PROBE_TX_PARITY_EN
         parity_q  <= parity_d;
         `endif
      end
   end

   // Next state: walk the frame on bit-timer ticks, abort returns to IDLE
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      win_cnt_d = win_cnt_q;
      `ifdef PROBE_TX_PARITY_EN
      parity_d  = parity_q;
      `endif
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  state_d   = ST_START;
                  shift_d   = data_in;
                  bit_cnt_d = '0;
                  `ifdef PROBE_TX_PARITY_EN
                  parity_d  = ^data_in;
                  `endif
               end
            end
            ST_START: begin
               if (tick) begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (bit_cnt_q == BIT_LAST) begin
                     `ifdef PROBE_TX_PARITY_EN
                     state_d = ST_PARITY;
                     `else
                     state_d = ST_STOP;
                     `endif
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                     shift_d   = shift_q >> 1;
                  end
               end
            end
            `ifdef PROBE_TX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  state_d = ST_STOP;
               end
            end
            `endif
            ST_STOP: begin
               if (tick) begin
                  state_d   = ST_WINDOW;
                  win_cnt_d = '0;
               end
            end
            ST_WINDOW: begin
               if (win_cnt_q == WIN_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output values for the state being entered on this edge
   always_comb begin
      tx_d     = LINE_IDLE;
      win_en_d = 1'b0;
      ready_d  = (state_d == ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
      // Completion only on the natural end of the window, never on abort
      done_d   = (state_q == ST_WINDOW) && (state_d == ST_IDLE) && !abort;
      case (state_d)
         ST_START:  tx_d = ~LINE_IDLE;
         ST_DATA:   tx_d = shift_d[0];
         `ifdef PROBE_TX_PARITY_EN
         ST_PARITY: tx_d = parity_d;
         `endif
         ST_WINDOW: win_en_d = 1'b1;
         default:   tx_d = LINE_IDLE;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q     <= LINE_IDLE;
         win_en_q <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         tx_q     <= tx_d;
         win_en_q <= win_en_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx         = tx_q;
   assign win_en     = win_en_q;
   assign data_ready = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_probe_tx.sv
// Bench for probe_tx: a per-cycle scoreboard of expected tx/win_en/done/
// busy/data_ready values is filled from a reference frame model when a word
// is handed over and drained by a monitor one step after each rising edge.
module tb_probe_tx;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
   localparam int WIN    = 16;
   `ifdef PROBE_TX_PARITY_EN
   localparam int SLOTS  = DATA_W + 3;
   `else
   localparam int SLOTS  = DATA_W + 2;
   `endif
   localparam int FRAME  = SLOTS * CPB;
   localparam int TOTAL  = FRAME + WIN + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              data_valid = 1'b0;
   logic              abort = 1'b0;
   logic              data_ready, tx, win_en, busy, done;

   typedef struct packed {
      logic tx;
      logic win;
      logic done;
      logic busy;
      logic ready;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   probe_tx #(
      .DATA_W        (DATA_W),
      .CLKS_PER_BIT  (CPB),
      .WINDOW_CYCLES (WIN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .abort      (abort),
      .tx         (tx),
      .win_en     (win_en),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, req, $time);
      end
   endtask

   // Reference: outputs c cycles after the accepting edge
   function automatic exp_t model(input logic [DATA_W-1:0] w, input int c);
      exp_t e;
      int   slot;
      e = '0;
      e.tx = 1'b1;
      e.ready = 1'b1;
      if (c < FRAME) begin
         slot = c / CPB;
         e.busy = 1'b1;
         e.ready = 1'b0;
         if (slot == 0)            e.tx = 1'b0;
         else if (slot <= DATA_W)  e.tx = w[slot-1];
         else if (slot == SLOTS-1) e.tx = 1'b1;
         else                      e.tx = ^w;
      end else if (c < FRAME + WIN) begin
         e.win = 1'b1;
         e.busy = 1'b1;
         e.ready = 1'b0;
      end else if (c == FRAME + WIN) begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   task automatic push_frame(input logic [DATA_W-1:0] w, input int n);
      for (int c = 0; c < n; c++) exp_q.push_back(model(w, c));
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e = '0;
      e.tx = 1'b1;
      e.ready = 1'b1;
      for (int c = 0; c < n; c++) exp_q.push_back(e);
   endtask

   // Offer w, push n expected cycles on the accepting edge
   task automatic send(input logic [DATA_W-1:0] w, input int n, input bit hold);
      @(negedge clk);
      data_in = w;
      data_valid = 1'b1;
      chk("ready_before_accept", 32'(data_ready), 32'd1);
      @(posedge clk);
      push_frame(w, n);
      if (!hold) begin
         #2;
         data_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Window start/length and done position relative to the accept edge
   task automatic measure();
      int win_first, win_len, done_at, done_cnt;
      win_first = -1;
      win_len = 0;
      done_at = -1;
      done_cnt = 0;
      for (int i = 1; i <= TOTAL + 3; i++) begin
         @(posedge clk);
         #1;
         if (win_en) begin
            win_len++;
            if (win_first < 0) win_first = i;
         end
         if (done) begin
            done_cnt++;
            done_at = i;
         end
      end
      chk("win_start", win_first, FRAME);
      chk("win_len", win_len, WIN);
      chk("done_at", done_at, FRAME + WIN);
      chk("done_count", done_cnt, 1);
   endtask

   // Scoreboard monitor
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("tx", 32'(tx), 32'(mon_e.tx));
         chk("win_en", 32'(win_en), 32'(mon_e.win));
         chk("done", 32'(done), 32'(mon_e.done));
         chk("busy", 32'(busy), 32'(mon_e.busy));
         chk("data_ready", 32'(data_ready), 32'(mon_e.ready));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_win_en", 32'(win_en), 32'd0);
      chk("rst_ready", 32'(data_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_idle(3);
      wait_drain(20);

      // Single frame 0xA5 with timing measurement
      send(8'hA5, TOTAL, 1'b0);
      measure();
      wait_drain(20);

      // Back-to-back 0x3C then 0xC3 with data_valid held high
      send(8'h3C, TOTAL, 1'b1);
      repeat (TOTAL - 1) @(posedge clk);
      @(negedge clk);
      data_in = 8'hC3;
      @(posedge clk);
      push_frame(8'hC3, TOTAL);
      #2;
      data_valid = 1'b0;
      push_idle(3);
      wait_drain(200);

      // Abort during data bit 3 of 0xFF
      send(8'hFF, 18, 1'b0);
      push_idle(50);
      repeat (17) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #2;
      abort = 1'b0;
      wait_drain(200);

      // Asynchronous reset in the middle of the window
      send(8'h81, FRAME + 6, 1'b0);
      repeat (FRAME + 5) @(posedge clk);
      @(negedge clk);
      chk("win_before_reset", 32'(win_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_win_en", 32'(win_en), 32'd0);
      chk("arst_tx", 32'(tx), 32'd1);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(data_ready), 32'd1);
      chk("arst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_idle(4);
      wait_drain(20);

      // 0x5A with data_in churn and stray data_valid pulses while busy
      send(8'h5A, TOTAL, 1'b0);
      push_idle(6);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         data_in = 8'($urandom);
         data_valid = (i % 3 == 0);
      end
      @(negedge clk);
      data_valid = 1'b0;
      wait_drain(200);

      // 0x01: odd weight, parity slot 1 when the parity build is used
      send(8'h01, TOTAL, 1'b0);
      measure();
      wait_drain(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
